joy2quad_multi: RTL and testbench
=================================

JOY2QUAD_MULTI -- requirements
Module: joy2quad_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent steering channels.
REQ-002 SHALL have parameter DIV_W, default 16: width of the step-period input.
REQ-003 SHALL have parameter ACCEL_HOLD, default 8: steps held in one direction before each speed-up.
REQ-004 SHALL have parameter ACCEL_MAX, default 3: maximum number of period halvings.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port clkdiv  input  DIV_W  base step period in CLK cycles, shared by all channels.
REQ-009 SHALL have port accel_en  input  1  1 = accelerating mode, 0 = constant-rate mode.
REQ-010 SHALL have port left  input  CHANNELS  per-channel left request, active high.
REQ-011 SHALL have port right  input  CHANNELS  per-channel right request, active high.
REQ-012 SHALL have port steer  output  2*CHANNELS  quadrature output, {A,B} for channel n at bits [2n+1:2n].
REQ-013 SHALL have port moving  output  CHANNELS  per-channel flag, high while a direction is active.

Function
REQ-014 SHALL derive the per-channel direction each cycle: right-only = forward, left-only = reverse, none or both = idle.
REQ-015 SHALL hold a 2-bit phase per channel that drives steer {A,B} directly from a register, with no combinational path from the inputs.
REQ-016 SHALL step the phase forward as 00->01->11->10->00 and in reverse as 00->10->11->01->00, one Gray step per tick.
REQ-017 SHALL compute the effective period as max(clkdiv >> level, 1), where level is the current acceleration level.
REQ-018 SHALL hold the divider at period-1 while idle, decrement it each cycle while active, issue a tick at 0 and reload it with period-1.
REQ-019 SHALL therefore produce the first step exactly period cycles after the direction becomes active.
REQ-020 SHALL apply a change of clkdiv at the next reload and never truncate a count already in progress.
REQ-021 SHALL, on idle or on a direction reversal, clear level and the held-step counter and reload the divider; on reversal the first step follows after a full base period.
REQ-022 SHALL, with accel_en=1, increment level (saturating at ACCEL_MAX) each time the held-step counter reaches ACCEL_HOLD, then clear that counter.
REQ-023 SHALL, with accel_en=0, hold level at 0.
REQ-024 SHALL register moving: it goes high one cycle after the direction becomes active and low one cycle after it becomes idle.
REQ-025 SHALL keep channels fully independent except for the shared clkdiv and accel_en.

Reset
REQ-026 SHALL, while reset is high, immediately force phase=00, steer=0, moving=0, level=0, held-step counter=0 and divider=0 for every channel.
REQ-027 SHALL, after reset deasserts, treat any held input as a new press governed by REQ-019.

Structure
REQ-028 SHALL place the direction enum (IDLE/FWD/REV), the Gray next-phase constants and the default parameter values in shared package joy2quad_pkg.
REQ-029 SHALL implement one channel in sub-module quad_chan, instantiated CHANNELS times by a generate loop.

Verification
REQ-030 SHALL cover: clkdiv=4, right[0] held -> steer[1:0] 00,01,11,10,00 with steps at cycles 4,8,12,16 after the press; moving[0]=1.
REQ-031 SHALL cover: clkdiv=4, left[0] held -> steer[1:0] 00,10,11,01; moving[0]=1.
REQ-032 SHALL cover: left[0]=right[0]=1 for 50 cycles -> steer[1:0] constant and moving[0]=0.
REQ-033 SHALL cover: accel_en=1, ACCEL_HOLD=4, ACCEL_MAX=2, clkdiv=16, right[1] held -> 4 steps at 16-cycle spacing, 4 at 8, then a steady 4; releasing restores 16-cycle spacing.
REQ-034 SHALL cover: reset pulsed mid-step -> steer and moving go to 0 before the next CLK edge; after release a held right gives its first step at clkdiv cycles.
REQ-035 SHALL cover: right[0] and left[1] active together -> ch0 counts forward and ch1 counts in reverse, each with correct spacing and no interaction.

Source files
------------

// File: rtl/joy2quad_pkg.sv
// rtl/joy2quad_pkg.sv - shared direction type, Gray step tables and defaults for joy2quad
package joy2quad_pkg;

  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_DIV_W      = 16;
  localparam int DEF_ACCEL_HOLD = 8;
  localparam int DEF_ACCEL_MAX  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FWD  = 2'b01,
    REV  = 2'b10
  } dir_t;

  // Next phase indexed by current phase: entry i lives at bits [2i+1:2i].
  localparam logic [7:0] GRAY_FWD = {2'b10, 2'b00, 2'b11, 2'b01};
  localparam logic [7:0] GRAY_REV = {2'b01, 2'b11, 2'b00, 2'b10};

  function automatic logic [1:0] gray_step(input logic [1:0] phase, input dir_t dir);
    logic [2:0] idx;
    idx = {phase, 1'b0};
    case (dir)
      FWD:     return GRAY_FWD[idx +: 2];
      REV:     return GRAY_REV[idx +: 2];
      default: return phase;
    endcase
  endfunction

endpackage

// File: rtl/quad_chan.sv
// rtl/quad_chan.sv - one steering channel: direction decode, accelerating divider, Gray phase
module quad_chan
  import joy2quad_pkg::*;
#(
  parameter int DIV_W      = DEF_DIV_W,
  parameter int ACCEL_HOLD = DEF_ACCEL_HOLD,
  parameter int ACCEL_MAX  = DEF_ACCEL_MAX
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             accel_en,
  input  logic             left,
  input  logic             right,
  output logic [1:0]       steer,
  output logic             moving
);

  localparam int LVL_W  = (ACCEL_MAX < 1) ? 1 : $clog2(ACCEL_MAX + 1);
  localparam int HOLD_W = (ACCEL_HOLD < 1) ? 1 : $clog2(ACCEL_HOLD + 1);
  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(ACCEL_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_HOLD - 1);

  // Reload value is period-1 with the period floored at one cycle.
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] div,
                                                  input logic [LVL_W-1:0] lvl);
    logic [DIV_W-1:0] p;
    p = div >> lvl;
    return (p == '0) ? '0 : p - DIV_W'(1);
  endfunction

  dir_t              dir, prev_dir;
  logic [1:0]        phase;
  logic [DIV_W-1:0]  div_cnt, cnt, next_div, base_reload;
  logic [LVL_W-1:0]  level, lvl_cur, next_level;
  logic [HOLD_W-1:0] hold_cnt, hold_cur, next_hold;
  logic              fresh, tick, hold_full;

  // A new press or a reversal restarts from a full base period in the same cycle.
  always_comb begin
    dir = IDLE;
    if (right && !left)      dir = FWD;
    else if (left && !right) dir = REV;
    fresh       = (dir != prev_dir);
    base_reload = reload_val(clkdiv, '0);
    cnt         = fresh ? base_reload : div_cnt;
    lvl_cur     = fresh ? '0 : level;
    hold_cur    = fresh ? '0 : hold_cnt;
    tick        = (dir != IDLE) && (cnt == '0);
    hold_full   = (hold_cur == HOLD_LAST);
    next_hold   = hold_cur;
    next_level  = lvl_cur;
    if (tick) begin
      next_hold = hold_full ? '0 : hold_cur + HOLD_W'(1);
      if (hold_full && (lvl_cur < LVL_MAX)) next_level = lvl_cur + LVL_W'(1);
    end
    if (!accel_en) next_level = '0;
    next_div = tick ? reload_val(clkdiv, next_level) : cnt - DIV_W'(1);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      phase    <= 2'b00;
      div_cnt  <= '0;
      level    <= '0;
      hold_cnt <= '0;
      prev_dir <= IDLE;
      moving   <= 1'b0;
    end else begin
      prev_dir <= dir;
      moving   <= (dir != IDLE);
      if (dir == IDLE) begin
        div_cnt  <= base_reload;
        level    <= '0;
        hold_cnt <= '0;
      end else begin
        div_cnt  <= next_div;
        level    <= next_level;
        hold_cnt <= next_hold;
        if (tick) phase <= gray_step(phase, dir);
      end
    end
  end

  assign steer = phase;

endmodule

// File: rtl/joy2quad_multi.sv
// rtl/joy2quad_multi.sv - multi-channel joystick to quadrature converter, one quad_chan per channel
module joy2quad_multi
  import joy2quad_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int ACCEL_HOLD = DEF_ACCEL_HOLD,
  parameter int ACCEL_MAX  = DEF_ACCEL_MAX
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic                  accel_en,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   moving
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    quad_chan #(
      .DIV_W      (DIV_W),
      .ACCEL_HOLD (ACCEL_HOLD),
      .ACCEL_MAX  (ACCEL_MAX)
    ) u_chan (
      .CLK      (CLK),
      .reset    (reset),
      .clkdiv   (clkdiv),
      .accel_en (accel_en),
      .left     (left[n]),
      .right    (right[n]),
      .steer    (steer[2*n +: 2]),
      .moving   (moving[n])
    );
  end

endmodule

// File: tb/tb_joy2quad_multi.sv
// tb/tb_joy2quad_multi.sv - table-driven bench with per-channel step scoreboard for joy2quad_multi
module tb_joy2quad_multi;

  localparam int HOLD = 4;
  localparam int AMAX = 2;
  localparam int DW   = 16;

  typedef struct {
    logic [1:0] l;
    logic [1:0] r;
    int         div;
    bit         accel;
    int         cycles;
    logic [1:0] mov;
    int         nsteps0;
    int         nsteps1;
  } vec_t;

  typedef struct {
    int         t;
    logic [1:0] v;
  } step_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          accel_en;
  logic [DW-1:0] clkdiv;
  logic [1:0]    left, right;
  logic [3:0]    steer;
  logic [1:0]    moving;

  joy2quad_multi #(
    .CHANNELS   (2),
    .DIV_W      (DW),
    .ACCEL_HOLD (HOLD),
    .ACCEL_MAX  (AMAX)
  ) dut (
    .CLK      (clk),
    .reset    (reset),
    .clkdiv   (clkdiv),
    .accel_en (accel_en),
    .left     (left),
    .right    (right),
    .steer    (steer),
    .moving   (moving)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_vec = 0;
  int         n_bad = 0;
  bit         quiet = 1'b1;
  logic [1:0] ph   [2];
  logic [1:0] prev [2];
  logic [1:0] mon_cur;
  step_t      mon_e;
  step_t      exp_q [2][$];
  vec_t       vecs  [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [1:0] next_ph(input logic [1:0] p, input bit rev);
    case (p)
      2'b00:   return rev ? 2'b10 : 2'b01;
      2'b01:   return rev ? 2'b00 : 2'b11;
      2'b11:   return rev ? 2'b01 : 2'b10;
      default: return rev ? 2'b11 : 2'b00;
    endcase
  endfunction

  task automatic push_one(input int ch, input bit rev, input int t);
    ph[ch] = next_ph(ph[ch], rev);
    exp_q[ch].push_back(step_t'{t, ph[ch]});
  endtask

  task automatic push_steps(input int ch, input bit rev, input int div, input bit accel,
                            input int n, input int c0);
    int t, lvl, p;
    t = c0;
    for (int k = 1; k <= n; k++) begin
      lvl = accel ? (((k - 1) / HOLD > AMAX) ? AMAX : (k - 1) / HOLD) : 0;
      p = div >> lvl;
      if (p < 1) p = 1;
      t += p;
      push_one(ch, rev, t);
    end
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      mon_cur = steer[2*ch +: 2];
      if (mon_cur !== prev[ch]) begin
        if (!quiet) begin
          if (exp_q[ch].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_step ch%0d: steer=%0b at cycle %0d, required no step",
                     ch, mon_cur, cyc);
          end else begin
            mon_e = exp_q[ch].pop_front();
            check($sformatf("step_cycle_ch%0d", ch), cyc, mon_e.t);
            check($sformatf("step_value_ch%0d", ch), {30'd0, mon_cur}, {30'd0, mon_e.v});
          end
        end
        prev[ch] = mon_cur;
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
    check("moving_off", {30'd0, moving}, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pending_ch0", exp_q[0].size(), 0);
    check("pending_ch1", exp_q[1].size(), 0);
    exp_q[0].delete();
    exp_q[1].delete();
  endtask

  task automatic run_vec(input vec_t v);
    int c0;
    @(posedge clk);
    #2;
    c0 = cyc;
    clkdiv = DW'(v.div);
    accel_en = v.accel;
    left = v.l;
    right = v.r;
    #1 check("moving_pre", {30'd0, moving}, 0);
    push_steps(0, v.l[0] & ~v.r[0], v.div, v.accel, v.nsteps0, c0);
    push_steps(1, v.l[1] & ~v.r[1], v.div, v.accel, v.nsteps1, c0);
    @(posedge clk);
    @(negedge clk);
    check("moving_on", {30'd0, moving}, {30'd0, v.mov});
    repeat (v.cycles - 1) @(posedge clk);
    #2;
    left = '0;
    right = '0;
    settle();
  endtask

  initial begin
    int c0, c1;
    //          l      r      div accel cyc  mov    n0  n1
    vecs[0] = '{2'b00, 2'b01, 4,  1'b0, 16,  2'b01, 4,  0};
    vecs[1] = '{2'b01, 2'b00, 4,  1'b0, 14,  2'b01, 3,  0};
    vecs[2] = '{2'b01, 2'b01, 4,  1'b0, 50,  2'b00, 0,  0};
    vecs[3] = '{2'b00, 2'b10, 16, 1'b1, 120, 2'b10, 0,  14};
    vecs[4] = '{2'b00, 2'b10, 16, 1'b1, 40,  2'b10, 0,  2};
    vecs[5] = '{2'b10, 2'b01, 5,  1'b0, 30,  2'b11, 6,  6};
    vecs[6] = '{2'b00, 2'b01, 1,  1'b0, 5,   2'b01, 5,  0};
    vecs[7] = '{2'b00, 2'b01, 0,  1'b0, 4,   2'b01, 4,  0};
    vecs[8] = '{2'b00, 2'b10, 2,  1'b1, 16,  2'b10, 0,  12};

    reset = 1'b1;
    accel_en = 1'b0;
    clkdiv = DW'(4);
    left = '0;
    right = '0;
    ph[0] = 2'b00;
    ph[1] = 2'b00;
    prev[0] = 2'b00;
    prev[1] = 2'b00;
    #1;
    check("reset_steer", {28'd0, steer}, 0);
    check("reset_moving", {30'd0, moving}, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    quiet = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reversal: the first reverse step needs a full base period.
    @(posedge clk);
    #2;
    c0 = cyc;
    clkdiv = DW'(4);
    accel_en = 1'b0;
    right = 2'b01;
    push_one(0, 1'b0, c0 + 4);
    repeat (6) @(posedge clk);
    #2;
    c1 = cyc;
    right = 2'b00;
    left = 2'b01;
    push_one(0, 1'b1, c1 + 4);
    push_one(0, 1'b1, c1 + 8);
    repeat (8) @(posedge clk);
    #2;
    left = '0;
    settle();

    // clkdiv change mid-count takes effect only at the next reload.
    @(posedge clk);
    #2;
    c0 = cyc;
    clkdiv = DW'(8);
    right = 2'b01;
    push_one(0, 1'b0, c0 + 8);
    push_one(0, 1'b0, c0 + 10);
    push_one(0, 1'b0, c0 + 12);
    repeat (3) @(posedge clk);
    #2;
    clkdiv = DW'(2);
    repeat (9) @(posedge clk);
    #2;
    right = '0;
    settle();

    // Asynchronous reset mid-step with the request still held.
    @(posedge clk);
    #2;
    c0 = cyc;
    clkdiv = DW'(4);
    right = 2'b01;
    push_one(0, 1'b0, c0 + 4);
    repeat (6) @(posedge clk);
    #2;
    quiet = 1'b1;
    reset = 1'b1;
    #1;
    check("async_rst_steer", {28'd0, steer}, 0);
    check("async_rst_moving", {30'd0, moving}, 0);
    ph[0] = 2'b00;
    ph[1] = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    quiet = 1'b0;
    c1 = cyc;
    push_one(0, 1'b0, c1 + 4);
    push_one(0, 1'b0, c1 + 8);
    repeat (8) @(posedge clk);
    #2;
    right = '0;
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
